// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with ready/valid handshake, flush/stall
// control and saturating stall/bubble counters. Define PIPE_SKID_EN to add a skid entry.
module pipe_stage_reg #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              v_q, v_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              push, pop;

`ifdef PIPE_SKID_EN
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  // Readiness depends only on local state, so out_ready never reaches in_ready.
  assign in_ready = ~stall & ~flush & ~s_v_q;
`else
  assign in_ready = ~stall & ~flush & (~v_q | out_ready);
`endif

  assign out_valid = v_q & ~stall;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
`ifdef PIPE_SKID_EN
    s_v_d    = s_v_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
`endif
    if (flush) begin
      v_d    = 1'b0;
      ctrl_d = '0;
`ifdef PIPE_SKID_EN
      s_v_d    = 1'b0;
      s_ctrl_d = '0;
`endif
    end else if (!stall) begin
`ifdef PIPE_SKID_EN
      if (pop) begin
        if (s_v_q) begin
          data_d = s_data_q;
          ctrl_d = s_ctrl_q;
          s_v_d  = 1'b0;
        end else if (push) begin
          data_d = in_data;
          ctrl_d = in_ctrl;
        end else begin
          v_d = 1'b0;
        end
      end else if (push) begin
        if (!v_q) begin
          v_d    = 1'b1;
          data_d = in_data;
          ctrl_d = in_ctrl;
        end else begin
          s_v_d    = 1'b1;
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end
      end
`else
      if (push) begin
        v_d    = 1'b1;
        data_d = in_data;
        ctrl_d = in_ctrl;
      end else if (pop) begin
        v_d = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (in_valid && !in_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!out_valid && out_ready && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // NOTE: the payload registers are reset as well, because out_data must read
  // zero straight out of reset; sequential state is updated with '<=' only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q          <= 1'b0;
      data_q       <= '0;
      ctrl_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      v_q          <= v_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_v_q    <= 1'b0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      s_v_q    <= s_v_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end
`endif

  assign out_data   = data_q;
  assign out_ctrl   = ctrl_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the stage is modelled as a flushable FIFO
// of depth 1 (depth 2 with PIPE_SKID_EN); a monitor compares every cycle.
module tb_pipe_stage_reg;

  localparam int DATA_W = 192;
  localparam int CTRL_W = 24;
  localparam int CNT_W  = 16;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  logic              sat_in_ready;
  logic              sat_out_valid;
  logic [7:0]        sat_out_data;
  logic [3:0]        sat_out_ctrl;
  logic [3:0]        sat_stall_cnt;
  logic [3:0]        sat_bubble_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance sharing the same controls, used for saturation.
  pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_data(in_data[7:0]), .in_ctrl(in_ctrl[3:0]), .stall(stall), .flush(flush),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_ctrl(sat_out_ctrl), .stall_cnt(sat_stall_cnt), .bubble_cnt(sat_bubble_cnt)
  );

  always #5 clk = ~clk;

  item_t             sb_q[$];
  int                checks = 0;
  int                failures = 0;
  int                stall_m = 0;
  int                bubble_m = 0;
  logic [CTRL_W-1:0] idle_ctrl = '0;
  bit                mon_en = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_ready(input bit st, input bit fl, input bit ordy, input int sz);
    if (st || fl) return 1'b0;
    if (DEPTH == 2) return sz < 2;
    return (sz == 0) || ordy;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: compares outputs against the model, pops on handshake, applies flush.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int  sz;
        bit  e_ir, e_ov;
        item_t popped;
        sz   = sb_q.size();
        e_ir = exp_ready(stall, flush, out_ready, sz);
        e_ov = (sz > 0) && !stall;
        check("in_ready", DATA_W'(in_ready), DATA_W'(e_ir));
        check("out_valid", DATA_W'(out_valid), DATA_W'(e_ov));
        check("sat_out_valid", DATA_W'(sat_out_valid), DATA_W'(e_ov));
        check("stall_cnt", DATA_W'(stall_cnt), DATA_W'(sat(stall_m, 65535)));
        check("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(sat(bubble_m, 65535)));
        check("sat_stall_cnt", DATA_W'(sat_stall_cnt), DATA_W'(sat(stall_m, 15)));
        check("sat_bubble_cnt", DATA_W'(sat_bubble_cnt), DATA_W'(sat(bubble_m, 15)));
        if (sz > 0) begin
          check("out_data", out_data, sb_q[0].d);
          check("out_ctrl", DATA_W'(out_ctrl), DATA_W'(sb_q[0].c));
        end else begin
          check("idle_ctrl", DATA_W'(out_ctrl), DATA_W'(idle_ctrl));
        end
        if (e_ov && out_ready) begin
          popped = sb_q.pop_front();
          if (sb_q.size() == 0) idle_ctrl = popped.c;
        end
        if (flush) begin
          sb_q.delete();
          idle_ctrl = '0;
        end
        if (in_valid && !e_ir) stall_m++;
        if (!e_ov && out_ready) bubble_m++;
      end
    end
  end

  // One cycle of stimulus; an accepted item is pushed after the monitor has run.
  task automatic drive(input bit iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input bit st, input bit fl, input bit ordy);
    bit acc;
    @(posedge clk); #1;
    in_valid = iv; in_data = d; in_ctrl = c;
    stall = st; flush = fl; out_ready = ordy;
    acc = iv && exp_ready(st, fl, ordy, sb_q.size());
    @(negedge clk); #1;
    if (acc) sb_q.push_back('{d, c});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, DATA_W'(out_valid), '0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_ctrl"}, DATA_W'(out_ctrl), '0);
    check({tag, "_stall_cnt"}, DATA_W'(stall_cnt), '0);
    check({tag, "_bubble_cnt"}, DATA_W'(bubble_cnt), '0);
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_state("mid_reset");
    sb_q.delete();
    stall_m = 0; bubble_m = 0; idle_ctrl = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    drive(1, DATA_W'(24'h001234), 24'h0000A5, 0, 0, 1);
    drive(0, '0, '0, 0, 0, 1);

    // Streaming 1..8 back to back.
    for (int k = 1; k <= 8; k++) drive(1, DATA_W'(k), CTRL_W'(k), 0, 0, 1);
    drive(0, '0, '0, 0, 0, 0);

    // Load one item, then stall for three cycles while it is held.
    drive(1, rand_data(), 24'h00C3C3, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(1, rand_data(), 24'h111111, 1, 0, 1);
    drive(0, '0, '0, 0, 0, 1);

    // Flush against a push, then flush together with stall.
    drive(1, rand_data(), 24'h0000AA, 0, 0, 0);
    drive(1, rand_data(), 24'h000FFF, 0, 1, 0);
    drive(1, rand_data(), 24'h000123, 0, 0, 0);
    drive(1, rand_data(), 24'h000FFF, 1, 1, 0);
    drive(0, '0, '0, 0, 0, 1);

    // Backpressure, then drain in order.
    for (int k = 0; k < 4; k++) drive(1, rand_data(), CTRL_W'($urandom), 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, '0, '0, 0, 0, 1);

    // Counter saturation on the narrow instance.
    for (int k = 0; k < 20; k++) drive(1, rand_data(), '0, 1, 0, 1);
    drive(0, '0, '0, 0, 0, 0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 9) < 7, rand_data(), CTRL_W'($urandom),
            $urandom_range(0, 19) < 3, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 6);

    mid_reset();
    for (int k = 0; k < 150; k++)
      drive($urandom_range(0, 9) < 6, rand_data(), CTRL_W'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) < 7);
    for (int k = 0; k < 4; k++) drive(0, '0, '0, 0, 0, 1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
